// File: rtl/pcie_trans_pkg.sv
// Shared definitions for the PCIE transaction-path VC scheduler:
// FSM encoding and word field positions.
package pcie_trans_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int VC_BIT     = 5;
  localparam int DEST_BIT   = 4;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vc_arbiter_if.sv
// VC-FIFO / destination-FIFO handshake bundle for vc_arbiter.
// master: the arbiter side; slave: the FIFO side.
interface vc_arbiter_if import pcie_trans_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              vc0_empty;
  logic [DATA_W-1:0] vc0_data;
  logic              vc1_empty;
  logic [DATA_W-1:0] vc1_data;
  logic              vc0_pop;
  logic              vc1_pop;
  logic              d0_almost_full;
  logic              d1_almost_full;
  logic              d0_full;
  logic              d1_full;
  logic [DATA_W-1:0] d_data;
  logic              d0_push;
  logic              d1_push;

  modport master (
    input  vc0_empty, vc0_data, vc1_empty, vc1_data,
    input  d0_almost_full, d1_almost_full, d0_full, d1_full,
    output vc0_pop, vc1_pop, d_data, d0_push, d1_push
  );

  modport slave (
    output vc0_empty, vc0_data, vc1_empty, vc1_data,
    output d0_almost_full, d1_almost_full, d0_full, d1_full,
    input  vc0_pop, vc1_pop, d_data, d0_push, d1_push
  );

endinterface

// File: rtl/vc_arbiter_wrr_pick.sv
// Weighted round-robin pick between two VCs, VC0 favoured.
// VC1 wins a contended cycle once VC0 has taken 'weight' grants in a row.
module vc_wrr_pick #(
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                elig0,
  input  logic                elig1,
  input  logic [WEIGHT_W-1:0] weight,
  output logic                gnt0,
  output logic                gnt1
);

  logic [WEIGHT_W-1:0] credit_q, credit_d;

  function automatic logic [WEIGHT_W-1:0] sat_inc(input logic [WEIGHT_W-1:0] v,
                                                  input logic [WEIGHT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (elig0 && elig1) begin
        if (credit_q >= weight) gnt1 = 1'b1;
        else                    gnt0 = 1'b1;
      end else if (elig0) begin
        gnt0 = 1'b1;
      end else if (elig1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Credit only accumulates while VC1 is actually waiting; a lowered weight clamps it.
  always_comb begin
    credit_d = credit_q;
    if (!elig1 || gnt1)         credit_d = '0;
    else if (gnt0)              credit_d = sat_inc(credit_q, weight);
    else if (credit_q > weight) credit_d = weight;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) credit_q <= '0;
    else       credit_q <= credit_d;
  end

endmodule

// File: rtl/vc_arbiter.sv
// VC0/VC1 -> D0/D1 scheduler: FSM, one-word-per-cycle grant, registered push stage,
// sticky overflow error. Define ARB_STATS_EN to add per-VC grant counters.
module vc_arbiter import pcie_trans_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = 4
`ifdef ARB_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] weight_cfg,
  vc_arbiter_if.master        bus,
  output logic                active_out,
  output logic                idle_out,
  output logic                error_out
`ifdef ARB_STATS_EN
  , output logic [STAT_W-1:0] grant_cnt_vc0
  , output logic [STAT_W-1:0] grant_cnt_vc1
`endif
);

  arb_state_e          state_q, state_d;
  logic [WEIGHT_W-1:0] weight_q;
  logic                elig0, elig1, gnt0, gnt1, gnt_any, grant_en;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   d_data_p1;
  logic                vld0_p1, vld1_p1;
  logic                error_q;

  function automatic logic [WEIGHT_W-1:0] cfg_weight(input logic [WEIGHT_W-1:0] cfg);
    return (cfg == '0) ? WEIGHT_W'(1) : cfg;
  endfunction

  // Head-of-line eligibility: each VC is blocked only by its own head's destination.
  assign elig0 = !bus.vc0_empty &&
                 !(bus.vc0_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
  assign elig1 = !bus.vc1_empty &&
                 !(bus.vc1_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
  assign grant_en = (state_q != ST_INIT) && !init;

  vc_wrr_pick #(.WEIGHT_W(WEIGHT_W)) u_pick (
    .clk   (clk),
    .reset (reset),
    .en    (grant_en),
    .elig0 (elig0),
    .elig1 (elig1),
    .weight(weight_q),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign gnt_any     = gnt0 | gnt1;
  assign sel_data    = gnt1 ? bus.vc1_data : bus.vc0_data;
  assign bus.vc0_pop = gnt0;
  assign bus.vc1_pop = gnt1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE:   if (init) state_d = ST_INIT;
                 else if (elig0 || elig1) state_d = ST_ACTIVE;
      ST_ACTIVE: if (init) state_d = ST_INIT;
                 else if (!(elig0 || elig1)) state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INIT;
      weight_q <= WEIGHT_W'(1);
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) weight_q <= cfg_weight(weight_cfg);
      if ((vld0_p1 && bus.d0_full) || (vld1_p1 && bus.d1_full)) error_q <= 1'b1;
    end
  end

  // p0 -> p1: granted word and its destination push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_data_p1 <= '0;
      vld0_p1   <= 1'b0;
      vld1_p1   <= 1'b0;
    end else begin
      vld0_p1 <= gnt_any && !sel_data[DEST_BIT];
      vld1_p1 <= gnt_any &&  sel_data[DEST_BIT];
      if (gnt_any) d_data_p1 <= sel_data;
    end
  end

  assign bus.d_data  = d_data_p1;
  assign bus.d0_push = vld0_p1;
  assign bus.d1_push = vld1_p1;
  assign active_out  = (state_q == ST_ACTIVE);
  assign idle_out    = (state_q == ST_IDLE) && !(vld0_p1 || vld1_p1);
  assign error_out   = error_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_d == ST_INIT && state_q != ST_INIT) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0) cnt0_q <= cnt0_q + 1'b1;
      if (gnt1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign grant_cnt_vc0 = cnt0_q;
  assign grant_cnt_vc1 = cnt1_q;
`endif

endmodule
